// File: rtl/aes_reg_pkg.sv
// ---------------------------------------------------------------------------
// aes_reg_pkg
// Shared definitions for the AES256 block/word register pair (4-to-16 input
// collector and 16-to-4 output serializer).
//   NBYTES : bytes per block
//   NWORD  : bytes per host word
//   DW     : bits per byte
//   byte_t / word_t / block_t : packed byte containers, element 0 = byte 0
//   ser_state_t : serializer state (EMPTY, SEND)
// ---------------------------------------------------------------------------
package aes_reg_pkg;

  localparam int NBYTES = 16;
  localparam int NWORD  = 4;
  localparam int DW     = 8;
  localparam int NWORDS = NBYTES / NWORD;
  localparam int CW     = $clog2(NWORDS);

  typedef logic [DW-1:0]      byte_t;
  typedef byte_t [NWORD-1:0]  word_t;
  typedef byte_t [NBYTES-1:0] block_t;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } ser_state_t;

endpackage

// File: rtl/mod_reg16_16to4.sv
// ---------------------------------------------------------------------------
// mod_reg16_16to4
// Output serializer of the AES256 core. Captures a finished 16-byte block in
// one cycle and emits it as four 4-byte words over a valid/ready handshake.
// Word k, byte j carries block byte 4k+j.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset
//   wr_en     : load strobe ("block done") from the core
//   i         : block to capture
//   rd_en     : consumer ready; transfer = o_valid && rd_en at a rising edge
//   o         : current output word (registered)
//   o_valid   : o holds a valid word
//   o_last    : o is the final word of the block (qualified by o_valid)
//   reg_empty : no block held, a load will be accepted
//   wr_err    : one-cycle pulse when a load is dropped because a block is
//               still being sent
// ---------------------------------------------------------------------------
module mod_reg16_16to4
  import aes_reg_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   wr_en,
  input  block_t i,
  input  logic   rd_en,
  output word_t  o,
  output logic   o_valid,
  output logic   o_last,
  output logic   reg_empty,
  output logic   wr_err
);

  ser_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  block_t          buf_q, buf_d;
  word_t           o_q, o_d;
  logic            o_valid_q, o_valid_d;
  logic            o_last_q, o_last_d;
  logic            reg_empty_q, reg_empty_d;
  logic            wr_err_q, wr_err_d;

  logic            transfer;
  logic            last_word;
  logic [CW-1:0]   cnt_inc;
  logic [CW+1:0]   next_base;

  assign transfer  = o_valid_q && rd_en;
  assign last_word = (cnt_q == CW'(NWORDS - 1));
  assign cnt_inc   = cnt_q + CW'(1);
  // Byte offset of the next word inside the buffer (counter * NWORD).
  assign next_base = {cnt_inc, 2'b00};

  // Next-state and output computation. Every register holds unless a load
  // or a transfer says otherwise; wr_err defaults low so it only pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    o_d         = o_q;
    o_valid_d   = o_valid_q;
    o_last_d    = o_last_q;
    reg_empty_d = reg_empty_q;
    wr_err_d    = 1'b0;

    unique case (state_q)
      EMPTY: begin
        o_valid_d = 1'b0;
        if (wr_en) begin
          buf_d       = i;
          cnt_d       = '0;
          o_d         = i[NWORD-1:0];
          o_valid_d   = 1'b1;
          o_last_d    = 1'b0;
          reg_empty_d = 1'b0;
          state_d     = SEND;
        end
      end

      SEND: begin
        if (transfer && last_word) begin
          if (wr_en) begin
            // Back-to-back load: first word of the new block follows the
            // last word of the old one with no bubble.
            buf_d    = i;
            cnt_d    = '0;
            o_d      = i[NWORD-1:0];
            o_last_d = 1'b0;
          end else begin
            // o keeps its last value; only the qualifiers drop.
            cnt_d       = '0;
            o_valid_d   = 1'b0;
            o_last_d    = 1'b0;
            reg_empty_d = 1'b1;
            state_d     = EMPTY;
          end
        end else begin
          if (transfer) begin
            cnt_d    = cnt_inc;
            o_d      = buf_q[next_base +: NWORD];
            o_last_d = (cnt_inc == CW'(NWORDS - 1));
          end
          // A load while the block is still draining is dropped.
          if (wr_en) begin
            wr_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State register; reset discards any partially sent block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      buf_q       <= '0;
      o_q         <= '0;
      o_valid_q   <= 1'b0;
      o_last_q    <= 1'b0;
      reg_empty_q <= 1'b1;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      o_q         <= o_d;
      o_valid_q   <= o_valid_d;
      o_last_q    <= o_last_d;
      reg_empty_q <= reg_empty_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign o         = o_q;
  assign o_valid   = o_valid_q;
  assign o_last    = o_last_q;
  assign reg_empty = reg_empty_q;
  assign wr_err    = wr_err_q;

endmodule

// File: doc/mod_reg16_16to4.md
Name: mod_reg16_16to4

Overview:
- Output serializer of the AES256 IP core, directly downstream of the round datapath.
- Captures a finished 16-byte state/ciphertext block in one cycle.
- Emits the block as four 4-byte words over a valid/ready handshake to the 32-bit host/output interface.
- Mirror of the 4-to-16 input collector. Byte ordering matches that block: word k, byte j = block byte 4k+j.

Parameters:
- NBYTES, 16, bytes per block captured on load.
- NWORD, 4, bytes per emitted word (NBYTES/NWORD = 4 words per block).
- DW, 8, bits per byte.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  load strobe from core ("block done"); sampled on rising edge.
- i  in  [NBYTES-1:0][DW-1:0]  block to capture.
- rd_en  in  1  consumer ready; a transfer occurs when o_valid && rd_en at a rising edge.
- o  out  [NWORD-1:0][DW-1:0]  current output word, registered.
- o_valid  out  1  o holds a valid word.
- o_last  out  1  o is word 3 of the block; qualified by o_valid.
- reg_empty  out  1  no block held; a load will be accepted.
- wr_err  out  1  one-cycle pulse when wr_en arrives while a block is still being sent.

Behaviour:
- Reset (async, any time, including mid-transfer): o=0, o_valid=0, o_last=0, reg_empty=1, wr_err=0, word counter=0, buffer=0, state=EMPTY. Any partial block is discarded.
- States: EMPTY and SEND.
- EMPTY, wr_en=1:
  - buffer<=i, counter<=0, state<=SEND, reg_empty<=0.
  - Next cycle: o_valid=1, o[j]=i[j] for j=0..3, o_last=0.
  - Load-to-first-word latency: 1 cycle.
- EMPTY, wr_en=0: outputs hold, o_valid=0.
- SEND, transfer with counter<3:
  - counter<=counter+1.
  - o<=buffer bytes 4(counter+1)..4(counter+1)+3.
  - o_valid stays 1. o_last=1 when the new counter==3.
- SEND, no transfer (rd_en=0): o, o_valid and o_last hold stable. Back-pressure of unlimited length is allowed.
- SEND, transfer with counter==3:
  - Without wr_en: state<=EMPTY, o_valid<=0, o_last<=0, reg_empty<=1, counter<=0. o holds its last value.
  - With wr_en in the same cycle: back-to-back load. buffer<=i, counter<=0, o<=i word 0, o_valid stays 1, o_last<=0, reg_empty stays 0. No bubble.
- SEND, wr_en with no final transfer: the load is ignored, buffer is unchanged, and wr_err=1 for exactly that cycle. The upstream core must gate on reg_empty.
- Throughput: with rd_en held high, one word per cycle. wr_en at edge T gives words 0..3 valid at cycles T+1..T+4.
- Counter: 2 bits, never wraps while in EMPTY. Word selection is buffer[counter*NWORD +: NWORD].
- o only changes on a load or a transfer. rd_en with o_valid=0 has no effect.

Decomposition:
- Shared package aes_reg_pkg:
  - NBYTES, NWORD, DW constants.
  - typedef byte_t (logic [7:0]).
  - typedef word_t ([NWORD-1:0] byte_t).
  - typedef block_t ([NBYTES-1:0] byte_t).
  - enum ser_state_t {EMPTY, SEND}.
- The package is shared with the 4-to-16 collector.
- No sub-module. The word selector is a single indexed part-select inside the block.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> o=0, o_valid=0, reg_empty=1, wr_err=0 for 5 cycles.
- Single block, rd_en held 1: i = bytes 0x00..0x0F (byte n = n), wr_en one cycle -> o = {00,01,02,03}, {04..07}, {08..0B}, {0C..0F} on 4 consecutive cycles; o_last only on the 4th; then o_valid=0, reg_empty=1.
- Back-pressure: same block, rd_en=0 for 3 cycles after the load -> word {00..03} stable with o_valid=1; raising rd_en resumes the sequence with no skipped or repeated word.
- Back-to-back: block A = 0x00..0x0F, then block B = 0x10..0x1F with wr_en coincident with A's final transfer -> the cycle after {0C..0F} shows {10..13}, o_valid never drops, reg_empty stays 0.
- Overrun: wr_en with block 0xFF.. while A's word 1 is pending -> wr_err pulses one cycle; A's remaining words {04..07}..{0C..0F} are emitted unchanged.
- Mid-transfer reset: assert reset asynchronously between clock edges after word 1 -> o=0, o_valid=0, reg_empty=1 immediately; a new load after release starts at word 0.
